vector_regfile_sb: RTL and testbench
====================================

Name: vector_regfile_sb

Overview:
- Parametrised multi-entry vector register file with per-lane write masking, one write port, two registered read ports, write-to-read bypass and a per-register busy scoreboard.
- Sits between the vector datapath and its multi-cycle execution units.
- A register is reserved when a long operation issues and released by the write-back. Reads of a reserved register are flagged not-valid so the issuing logic stalls.

Parameters:
- DATA_W, 512, register width in bits.
- LANE_W, 32, lane granularity for masked writes; DATA_W must be a multiple of LANE_W.
- DEPTH, 4, number of registers, 2..64, need not be a power of two.
- Derived, not overridable: LANES = DATA_W/LANE_W; ADDR_W = max(1, clog2(DEPTH)).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous clear of all registers and busy bits.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_mask  in  LANES  lane enable; bit i covers bits [i*LANE_W +: LANE_W].
- rsv_en  in  1  reserve strobe.
- rsv_addr  in  ADDR_W  register to mark busy.
- rsv_err  out  1  registered pulse: reserve of an already-busy or out-of-range register.
- rd0_en  in  1  read port 0 request.
- rd0_addr  in  ADDR_W  read port 0 address.
- rd0_data  out  DATA_W  read port 0 data.
- rd0_valid  out  1  read port 0 data valid and register not busy.
- rd1_en, rd1_addr, rd1_data, rd1_valid: same as port 0.
- busy  out  DEPTH  busy bitmap, bit n = register n busy.

Behaviour:
- Reset (async): all registers = 0, busy = 0, rd0_data = rd1_data = 0, rd0_valid = rd1_valid = 0, rsv_err = 0.
- Write: on a clock edge with wr_en=1 and wr_addr<DEPTH, lanes with wr_mask[i]=1 take wr_data; other lanes hold. wr_mask=0 changes no data but still clears busy. wr_addr>=DEPTH: no effect.
- Write to a non-busy register is legal; it only updates data.
- Busy set: rsv_en=1, rsv_addr<DEPTH and busy[rsv_addr]=0 sets busy[rsv_addr] at the edge.
  - If the register is already busy, or rsv_addr>=DEPTH: no state change; rsv_err=1 for exactly one cycle.
- Busy clear: wr_en=1 with wr_addr<DEPTH clears busy[wr_addr] at the edge.
- Write and reserve to the same address in the same cycle:
  - Write data lands.
  - The reserve is evaluated against the post-write state, so busy ends at 1 and rsv_err=0 (back-to-back long ops).
- Read latency is 1 cycle. rdN_en=1 in cycle t gives rdN_data/rdN_valid in cycle t+1. rdN_en=0 holds rdN_data and drives rdN_valid=0 the next cycle.
- Bypass: if a write hits the same in-range address as a read in the same cycle, rdN_data returns the merged value (new lanes where wr_mask=1, old lanes elsewhere).
- rdN_valid(t+1) = rdN_en & (rdN_addr<DEPTH) & ~busy_next[rdN_addr], where busy_next is busy after that edge's write/reserve update.
  - A read in the same cycle as the releasing write is valid.
  - A read in the same cycle as a reserve of that address is not valid.
- Out-of-range read: rdN_data = 0, rdN_valid = 0.
- Busy reads still return the current register data; only valid is low.
- Both ports may read the same address independently.
- clear=1 (synchronous) zeros all registers and busy bits. It overrides wr_en and rsv_en in the same cycle; rsv_err=0 that cycle.
  - Reads issued in the clear cycle return 0 with valid as rdN_en & in-range.
- busy is a direct register output; its reset value is 0.
- Reset mid-operation: all outstanding reservations are dropped and nothing completes. A write-back after reset is a plain write.

Test Plan:
- Reset, then write reg2 = 512'h...A5 with full mask; read port0 reg2 next cycle -> rd0_data = pattern, rd0_valid = 1 one cycle after rd0_en.
- Write reg1 all-ones, then write reg1 = 0 with wr_mask=16'h0001 while rd1 reads reg1 in the same cycle -> rd1_data = lane0 zero, lanes 1-15 all-ones (bypass).
- Reserve reg3; read reg3 -> rd0_valid = 0, busy = 4'b1000; reserve reg3 again -> rsv_err pulses 1 cycle, busy unchanged; write reg3 with read reg3 in the same cycle -> rd0_valid = 1, busy = 0.
- Same cycle write+reserve reg0 -> busy[0] = 1, rsv_err = 0, data updated.
- DEPTH=5 build: write/read/reserve address 6 -> no state change, rd_valid = 0, rd_data = 0, rsv_err = 1.
- Reserve reg1 and write reg2, then assert reset mid-cycle (async) -> busy = 0 and all outputs 0 immediately. Pulse clear with wr_en high -> all registers read 0.

Source files
------------

// File: rtl/vector_regfile_sb.sv
// Vector register file: lane-masked write port, two registered read ports with
// write-to-read bypass, and a per-register busy scoreboard for long operations.
module vector_regfile_sb #(
    parameter  int DATA_W = 512,
    parameter  int LANE_W = 32,
    parameter  int DEPTH  = 4,
    localparam int LANES  = DATA_W / LANE_W,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LANES-1:0]  wr_mask,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_err,
    input  logic              rd0_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic              rd0_valid,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_valid,
    output logic [DEPTH-1:0]  busy
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    // Replace the lanes selected by mask with the new value, keep the rest.
    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic [LANES-1:0]  mask);
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) r[i*LANE_W +: LANE_W] = new_v[i*LANE_W +: LANE_W];
        end
        return r;
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_hit;
    logic [DEPTH-1:0]  busy_wr;
    logic [DEPTH-1:0]  busy_next;
    logic              rsv_free;
    logic              rsv_err_next;

    logic [1:0]        rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a [2];
    logic [DATA_W-1:0] rd_data_d [2];
    logic [1:0]        vld_d;
    logic [DATA_W-1:0] rd_data_p1 [2];
    logic [1:0]        vld_p1;

    assign rd_en_a      = {rd1_en, rd0_en};
    assign rd_addr_a[0] = rd0_addr;
    assign rd_addr_a[1] = rd1_addr;

    // Scoreboard update: the write releases first, then the reserve is judged
    // against that, so a write-back and a new reserve of one register chain cleanly.
    always_comb begin
        wr_hit   = wr_en & in_range(wr_addr);
        busy_wr  = busy;
        rsv_free = 1'b0;
        for (int n = 0; n < DEPTH; n++) begin
            if (wr_hit && wr_addr == ADDR_W'(n)) busy_wr[n] = 1'b0;
        end
        for (int n = 0; n < DEPTH; n++) begin
            if (rsv_addr == ADDR_W'(n) && !busy_wr[n]) rsv_free = 1'b1;
        end
        busy_next = busy_wr;
        for (int n = 0; n < DEPTH; n++) begin
            if (rsv_en && rsv_free && rsv_addr == ADDR_W'(n)) busy_next[n] = 1'b1;
        end
        rsv_err_next = rsv_en & ~rsv_free & ~clear;
        if (clear) busy_next = '0;
    end

    // Read lookup with bypass of a same-cycle write; out-of-range reads see zero
    // and are never valid, busy registers still return their data.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            logic busy_bit;
            rd_data_d[p] = '0;
            busy_bit     = 1'b1;
            for (int n = 0; n < DEPTH; n++) begin
                if (rd_addr_a[p] == ADDR_W'(n)) begin
                    rd_data_d[p] = regs[n];
                    busy_bit     = busy_next[n];
                end
            end
            if (wr_hit && rd_addr_a[p] == wr_addr)
                rd_data_d[p] = lane_merge(rd_data_d[p], wr_data, wr_mask);
            if (clear) rd_data_d[p] = '0;
            vld_d[p] = rd_en_a[p] & ~busy_bit;
        end
    end

    // Register storage: clear wins over a write in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < DEPTH; n++) regs[n] <= '0;
        end else if (clear) begin
            for (int n = 0; n < DEPTH; n++) regs[n] <= '0;
        end else if (wr_hit) begin
            for (int n = 0; n < DEPTH; n++) begin
                if (wr_addr == ADDR_W'(n)) regs[n] <= lane_merge(regs[n], wr_data, wr_mask);
            end
        end
    end

    // Scoreboard and reserve-error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= '0;
            rsv_err <= 1'b0;
        end else begin
            busy    <= busy_next;
            rsv_err <= rsv_err_next;
        end
    end

    // ---- stage p1: read outputs; data holds when a port is idle ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_p1[0] <= '0;
            rd_data_p1[1] <= '0;
            vld_p1        <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (rd_en_a[p]) rd_data_p1[p] <= rd_data_d[p];
            end
            vld_p1 <= vld_d;
        end
    end

    assign rd0_data  = rd_data_p1[0];
    assign rd1_data  = rd_data_p1[1];
    assign rd0_valid = vld_p1[0];
    assign rd1_valid = vld_p1[1];

endmodule

// File: tb/tb_vector_regfile_sb.sv
// Bench for vector_regfile_sb (DEPTH=5 build so out-of-range addresses exist):
// hand-derived vector table, reset/clear sequences and a random run against
// a behavioural model of the register file state.
module tb_vector_regfile_sb;

    localparam int DATA_W = 512;
    localparam int LANE_W = 32;
    localparam int DEPTH  = 5;
    localparam int LANES  = 16;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [LANES-1:0]  wr_mask;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rsv_err;
    logic              rd0_en;
    logic [ADDR_W-1:0] rd0_addr;
    logic [DATA_W-1:0] rd0_data;
    logic              rd0_valid;
    logic              rd1_en;
    logic [ADDR_W-1:0] rd1_addr;
    logic [DATA_W-1:0] rd1_data;
    logic              rd1_valid;
    logic [DEPTH-1:0]  busy;

    vector_regfile_sb #(.DATA_W(DATA_W), .LANE_W(LANE_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_err(rsv_err),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_valid(rd0_valid),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_valid(rd1_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              clr;
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [LANES-1:0]  wm;
        logic              re;
        logic [ADDR_W-1:0] ra;
        logic              r0e;
        logic [ADDR_W-1:0] r0a;
        logic              r1e;
        logic [ADDR_W-1:0] r1a;
    } stim_t;

    typedef struct {
        stim_t             s;
        logic [DATA_W-1:0] d0;
        logic              v0;
        logic [DATA_W-1:0] d1;
        logic              v1;
        logic [DEPTH-1:0]  bz;
        logic              err;
    } vec_t;

    int nvec  = 0;
    int nfail = 0;

    // Behavioural model: register contents, busy flags, and what the outputs should show.
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic              m_busy [DEPTH];
    logic [DATA_W-1:0] m_d [2];
    logic              m_v [2];
    logic              m_err;

    function automatic stim_t st(input logic clr, input logic we, input logic [ADDR_W-1:0] wa,
                                 input logic [DATA_W-1:0] wd, input logic [LANES-1:0] wm,
                                 input logic re, input logic [ADDR_W-1:0] ra,
                                 input logic r0e, input logic [ADDR_W-1:0] r0a,
                                 input logic r1e, input logic [ADDR_W-1:0] r1a);
        stim_t s;
        s.clr = clr; s.we = we; s.wa = wa; s.wd = wd; s.wm = wm;
        s.re = re; s.ra = ra; s.r0e = r0e; s.r0a = r0a; s.r1e = r1e; s.r1a = r1a;
        return s;
    endfunction

    function automatic vec_t vx(input stim_t s, input logic [DATA_W-1:0] d0, input logic v0,
                                input logic [DATA_W-1:0] d1, input logic v1,
                                input logic [DEPTH-1:0] bz, input logic err);
        vec_t v;
        v.s = s; v.d0 = d0; v.v0 = v0; v.d1 = d1; v.v1 = v1; v.bz = bz; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply(input stim_t s);
        clear = s.clr; wr_en = s.we; wr_addr = s.wa; wr_data = s.wd; wr_mask = s.wm;
        rsv_en = s.re; rsv_addr = s.ra;
        rd0_en = s.r0e; rd0_addr = s.r0a; rd1_en = s.r1e; rd1_addr = s.r1a;
    endtask

    task automatic model_reset();
        for (int n = 0; n < DEPTH; n++) begin
            m_mem[n] = '0;
            m_busy[n] = 1'b0;
        end
        m_d[0] = '0; m_d[1] = '0; m_v[0] = 1'b0; m_v[1] = 1'b0; m_err = 1'b0;
    endtask

    // One clock edge of the register file: reads observe the state after the edge.
    task automatic model_step(input stim_t s);
        int a;
        m_err = 1'b0;
        if (s.clr) begin
            for (int n = 0; n < DEPTH; n++) begin
                m_mem[n] = '0;
                m_busy[n] = 1'b0;
            end
        end else begin
            a = int'(s.wa);
            if (s.we && a < DEPTH) begin
                for (int i = 0; i < LANES; i++)
                    if (s.wm[i]) m_mem[a][i*LANE_W +: LANE_W] = s.wd[i*LANE_W +: LANE_W];
                m_busy[a] = 1'b0;
            end
            a = int'(s.ra);
            if (s.re) begin
                if (a < DEPTH && !m_busy[a]) m_busy[a] = 1'b1;
                else m_err = 1'b1;
            end
        end
        for (int p = 0; p < 2; p++) begin
            logic en;
            en = (p == 0) ? s.r0e : s.r1e;
            a  = int'((p == 0) ? s.r0a : s.r1a);
            if (en) begin
                m_d[p] = (a < DEPTH) ? m_mem[a] : '0;
                m_v[p] = (a < DEPTH) && !m_busy[a];
            end else begin
                m_v[p] = 1'b0;
            end
        end
    endtask

    function automatic logic [DEPTH-1:0] model_busy();
        logic [DEPTH-1:0] b;
        for (int n = 0; n < DEPTH; n++) b[n] = m_busy[n];
        return b;
    endfunction

    // Apply one cycle of stimulus and compare every output against the model.
    task automatic mcyc(input stim_t s, input string tag);
        apply(s);
        model_step(s);
        @(posedge clk);
        #1;
        chk({tag, ".rd0_data"},  rd0_data,  m_d[0]);
        chk({tag, ".rd0_valid"}, DATA_W'(rd0_valid), DATA_W'(m_v[0]));
        chk({tag, ".rd1_data"},  rd1_data,  m_d[1]);
        chk({tag, ".rd1_valid"}, DATA_W'(rd1_valid), DATA_W'(m_v[1]));
        chk({tag, ".busy"},      DATA_W'(busy), DATA_W'(model_busy()));
        chk({tag, ".rsv_err"},   DATA_W'(rsv_err), DATA_W'(m_err));
    endtask

    vec_t              tbl [15];
    logic [DATA_W-1:0] pa5, p5a, pc3, ones, byp, px;
    stim_t             idle, s;

    initial begin
        pa5  = {64{8'hA5}};
        p5a  = {64{8'h5A}};
        pc3  = {64{8'hC3}};
        ones = '1;
        byp  = {{(DATA_W-LANE_W){1'b1}}, {LANE_W{1'b0}}};
        px   = {16{32'h1234_5678}};
        idle = st(0, 0, 0, '0, '0, 0, 0, 0, 0, 0, 0);

        //             clr we wa  wd    wm        re ra r0e r0a r1e r1a     d0   v0 d1    v1 busy     err
        tbl[0]  = vx(st(0, 1, 2, pa5,  16'hFFFF, 0, 0, 0, 0, 0, 0), '0,  0, '0,   0, 5'b00000, 0);
        tbl[1]  = vx(st(0, 0, 0, '0,   16'h0000, 0, 0, 1, 2, 0, 0), pa5, 1, '0,   0, 5'b00000, 0);
        tbl[2]  = vx(st(0, 1, 1, ones, 16'hFFFF, 0, 0, 0, 0, 0, 0), pa5, 0, '0,   0, 5'b00000, 0);
        tbl[3]  = vx(st(0, 1, 1, '0,   16'h0001, 0, 0, 0, 0, 1, 1), pa5, 0, byp,  1, 5'b00000, 0);
        tbl[4]  = vx(st(0, 0, 0, '0,   16'h0000, 1, 3, 1, 3, 0, 0), '0,  0, byp,  0, 5'b01000, 0);
        tbl[5]  = vx(st(0, 0, 0, '0,   16'h0000, 0, 0, 1, 3, 0, 0), '0,  0, byp,  0, 5'b01000, 0);
        tbl[6]  = vx(st(0, 0, 0, '0,   16'h0000, 1, 3, 0, 0, 0, 0), '0,  0, byp,  0, 5'b01000, 1);
        tbl[7]  = vx(st(0, 0, 0, '0,   16'h0000, 0, 0, 0, 0, 0, 0), '0,  0, byp,  0, 5'b01000, 0);
        tbl[8]  = vx(st(0, 1, 3, pc3,  16'hFFFF, 0, 0, 1, 3, 0, 0), pc3, 1, byp,  0, 5'b00000, 0);
        tbl[9]  = vx(st(0, 1, 0, p5a,  16'hFFFF, 1, 0, 0, 0, 1, 0), pc3, 0, p5a,  0, 5'b00001, 0);
        tbl[10] = vx(st(0, 0, 0, '0,   16'h0000, 0, 0, 1, 0, 0, 0), p5a, 0, p5a,  0, 5'b00001, 0);
        tbl[11] = vx(st(0, 1, 6, ones, 16'hFFFF, 1, 6, 1, 6, 1, 5), '0,  0, '0,   0, 5'b00001, 1);
        tbl[12] = vx(st(0, 0, 0, '0,   16'h0000, 0, 0, 1, 2, 1, 2), pa5, 1, pa5,  1, 5'b00001, 0);
        tbl[13] = vx(st(1, 1, 2, ones, 16'hFFFF, 1, 4, 1, 2, 1, 0), '0,  1, '0,   1, 5'b00000, 0);
        tbl[14] = vx(st(0, 0, 0, '0,   16'h0000, 0, 0, 1, 1, 1, 3), '0,  1, '0,   1, 5'b00000, 0);

        reset = 1'b1;
        apply(idle);
        model_reset();
        #12;
        chk("reset.rd0_data",  rd0_data, '0);
        chk("reset.rd0_valid", DATA_W'(rd0_valid), '0);
        chk("reset.rd1_data",  rd1_data, '0);
        chk("reset.rd1_valid", DATA_W'(rd1_valid), '0);
        chk("reset.busy",      DATA_W'(busy), '0);
        chk("reset.rsv_err",   DATA_W'(rsv_err), '0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].s);
            model_step(tbl[i].s);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.rd0_data", i),  rd0_data, tbl[i].d0);
            chk($sformatf("vec%0d.rd0_valid", i), DATA_W'(rd0_valid), DATA_W'(tbl[i].v0));
            chk($sformatf("vec%0d.rd1_data", i),  rd1_data, tbl[i].d1);
            chk($sformatf("vec%0d.rd1_valid", i), DATA_W'(rd1_valid), DATA_W'(tbl[i].v1));
            chk($sformatf("vec%0d.busy", i),      DATA_W'(busy), DATA_W'(tbl[i].bz));
            chk($sformatf("vec%0d.rsv_err", i),   DATA_W'(rsv_err), DATA_W'(tbl[i].err));
        end

        // Reserve reg1 and write reg2, then reset asynchronously between edges.
        mcyc(st(0, 1, 2, px, 16'hFFFF, 1, 1, 1, 2, 1, 2), "pre_reset");
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset.busy",      DATA_W'(busy), '0);
        chk("async_reset.rd0_data",  rd0_data, '0);
        chk("async_reset.rd0_valid", DATA_W'(rd0_valid), '0);
        chk("async_reset.rd1_data",  rd1_data, '0);
        chk("async_reset.rd1_valid", DATA_W'(rd1_valid), '0);
        chk("async_reset.rsv_err",   DATA_W'(rsv_err), '0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        // The late write-back is a plain write and the reservation stays dropped.
        mcyc(st(0, 1, 1, pc3, 16'hF0F0, 0, 0, 1, 1, 1, 2), "post_reset_wb");
        mcyc(st(0, 1, 3, ones, 16'hFFFF, 1, 4, 0, 0, 0, 0), "pre_clear");
        mcyc(st(1, 1, 3, ones, 16'hFFFF, 1, 2, 1, 3, 1, 1), "clear");
        mcyc(st(0, 0, 0, '0, '0, 0, 0, 1, 0, 1, 1), "after_clear01");
        mcyc(st(0, 0, 0, '0, '0, 0, 0, 1, 2, 1, 3), "after_clear23");
        mcyc(st(0, 0, 0, '0, '0, 0, 0, 1, 4, 1, 4), "after_clear4");

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            s.clr = ($urandom_range(0, 39) == 0);
            s.we  = $urandom_range(0, 1) == 1;
            s.wa  = ADDR_W'($urandom_range(0, 7));
            for (int i = 0; i < LANES; i++) s.wd[i*LANE_W +: LANE_W] = $urandom;
            s.wm  = ($urandom_range(0, 3) == 0) ? '1 : LANES'($urandom);
            s.re  = $urandom_range(0, 2) == 0;
            s.ra  = ADDR_W'($urandom_range(0, 7));
            s.r0e = $urandom_range(0, 3) != 0;
            s.r0a = ADDR_W'($urandom_range(0, 7));
            s.r1e = $urandom_range(0, 3) != 0;
            s.r1a = ($urandom_range(0, 3) == 0) ? s.wa : ADDR_W'($urandom_range(0, 7));
            mcyc(s, $sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
